// File: rtl/if_stage_pkg.sv
// Shared constants and FSM encoding for the ZeroCPU RV64 instruction-fetch stage.
package if_stage_pkg;

    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_out_reg.sv
// Holding register for the presented {pc, inst, exc, valid} fetch result.
module if_out_reg
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] pc_d,
    input  logic [31:0]     inst_d,
    input  logic            exc_d,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst,
    output logic            exc
);

    // load wins over clear so a misaligned redirect can replace a held result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
            exc   <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_d;
            inst  <= inst_d;
            exc   <= exc_d;
        end else if (clear) begin
            valid <= 1'b0;
            exc   <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding req/gnt/rvalid fetch, redirect flush.
// Optional feature macro: IFU_MISALIGN_CHECK_EN (misaligned redirect raises out_exc).
module if_stage
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall_i,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic            out_exc
);

    if_state_e       state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            drop_reg, drop_next;

    logic            out_load, out_clear, out_exc_d;
    logic [XLEN-1:0] out_pc_d;
    logic [31:0]     out_inst_d;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_plus4;
    logic            redirect_misaligned;
    logic            drain_pending;

`ifdef IFU_MISALIGN_CHECK_EN
    assign redirect_target     = redirect_pc;
    assign redirect_misaligned = |redirect_pc[1:0];
`else
    assign redirect_target     = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
    assign redirect_misaligned = 1'b0;
`endif

    assign pc_plus4  = pc_reg + {{(XLEN-3){1'b0}}, 3'd4};
    assign imem_req  = (state_reg == S_REQ);
    assign imem_addr = {pc_reg[XLEN-1:2], 2'b00};

    // A flushed request can still be outstanding in S_OUT after a misaligned
    // redirect; it must drain through S_WAIT before a new request issues.
    assign drain_pending = drop_reg & ~imem_rvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_REQ;
            pc_reg    <= RESET_PC;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            drop_reg  <= drop_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        drop_next  = drop_reg;
        out_load   = 1'b0;
        out_clear  = 1'b0;
        out_pc_d   = pc_reg;
        out_inst_d = imem_rdata;
        out_exc_d  = 1'b0;

        if (redirect_valid) begin
            pc_next   = redirect_target;
            out_clear = 1'b1;
            case (state_reg)
                S_REQ: begin
                    if (imem_gnt) begin
                        state_next = S_WAIT;
                        drop_next  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_next = S_REQ;
                        drop_next  = 1'b0;
                    end else begin
                        drop_next  = 1'b1;
                    end
                end
                default: begin
                    state_next = drain_pending ? S_WAIT : S_REQ;
                    drop_next  = drain_pending;
                end
            endcase
            if (redirect_misaligned) begin
                state_next = S_OUT;
                out_load   = 1'b1;
                out_pc_d   = redirect_pc;
                out_inst_d = NOP_INST;
                out_exc_d  = 1'b1;
            end
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (imem_gnt) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_reg) begin
                            drop_next  = 1'b0;
                            state_next = S_REQ;
                        end else begin
                            out_load   = 1'b1;
                            state_next = S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (drop_reg && imem_rvalid) drop_next = 1'b0;
                    if (!stall_i) begin
                        out_clear  = 1'b1;
                        pc_next    = pc_plus4;
                        state_next = drain_pending ? S_WAIT : S_REQ;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end
    end

    if_out_reg u_out_reg (
        .clk    (clk),
        .rst    (rst),
        .load   (out_load),
        .clear  (out_clear),
        .pc_d   (out_pc_d),
        .inst_d (out_inst_d),
        .exc_d  (out_exc_d),
        .valid  (out_valid),
        .pc     (out_pc),
        .inst   (out_inst),
        .exc    (out_exc)
    );

endmodule
